pipe_regs: RTL and testbench
============================

PIPE_REGS -- requirements
Module: pipe_regs

Interface
REQ-001 Parameter WIDTH, default 32, payload width in bits; legal range 1..1024.
REQ-002 Parameter DEPTH, default 2, number of register stages; DEPTH < 1 SHALL be an elaboration error.
REQ-003 Parameter RESET_VAL, default 0 (WIDTH bits), value loaded into every stage's data register on reset and on flush.
REQ-004 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset; asserted (0) clears all state immediately, deassertion is synchronised externally.
REQ-006 flush  input  1  synchronous pipeline clear, active-high.
REQ-007 in_valid  input  1  upstream beat present.
REQ-008 in_ready  output  1  block accepts a beat this cycle.
REQ-009 in_data  input  WIDTH  upstream payload.
REQ-010 out_valid  output  1  stage DEPTH-1 holds a beat.
REQ-011 out_ready  input  1  downstream accepts a beat this cycle.
REQ-012 out_data  output  WIDTH  payload of stage DEPTH-1.
REQ-013 occupancy  output  $clog2(DEPTH+1)  number of valid stages.

Function
REQ-014 Each stage i (0..DEPTH-1) SHALL hold a valid bit v[i] and a WIDTH-bit data register d[i].
REQ-015 Stage ready SHALL be r[i] = !v[i] || r[i+1], with r[DEPTH] = out_ready (bubble-collapsing); in_ready SHALL equal r[0] when flush = 0.
REQ-016 Transfer in occurs when in_valid && in_ready; transfer out occurs when out_valid && out_ready.
REQ-017 When r[i] = 1 and flush = 0, stage i SHALL load v[i] <= v[i-1] (or in_valid for i = 0) and d[i] <= d[i-1] (or in_data); when r[i] = 0, stage i SHALL hold.
REQ-018 d[i] SHALL load only when the incoming valid is 1; a bubble advancing into a stage clears v[i] but leaves d[i] unchanged.
REQ-019 Unstalled latency SHALL be exactly DEPTH cycles from in transfer to out_valid; full-pipeline throughput SHALL be one beat per cycle.
REQ-020 out_valid = v[DEPTH-1], out_data = d[DEPTH-1]; outputs SHALL be registered, no combinational path from in_data to out_data.
REQ-021 occupancy SHALL equal the population count of v[] after each edge, range 0..DEPTH.
REQ-022 flush = 1: in_ready and out_valid SHALL be forced 0 that cycle; at the next edge all v[i] <= 0 and d[i] <= RESET_VAL; any beat on in_data that cycle is discarded.
REQ-023 flush SHALL take priority over simultaneous in and out transfers; reset SHALL take priority over flush.
REQ-024 Full pipeline with out_ready = 1 and in_valid = 1 SHALL accept and emit in the same cycle (occupancy unchanged).
REQ-025 Full pipeline with out_ready = 0 SHALL hold all stages and drive in_ready = 0; data SHALL remain stable while out_valid && !out_ready.
REQ-026 Stalled pipeline with an internal bubble SHALL collapse the bubble: stages upstream of the bubble advance while downstream stages hold.

Reset
REQ-027 While reset = 0: all v[i] = 0, all d[i] = RESET_VAL, out_valid = 0, out_data = RESET_VAL, occupancy = 0, in_ready = 1.
REQ-028 Reset assertion mid-stream SHALL discard all in-flight beats without waiting for a clock edge.
REQ-029 First transfer SHALL be possible on the first rising edge after reset deasserts.

Structure
REQ-030 Shared package pipe_pkg SHALL hold the occupancy width function (clog2 of DEPTH+1) and the default WIDTH/DEPTH constants.
REQ-031 Sub-module pipe_stage (one valid bit plus WIDTH-bit register, enable, sync clear, async active-low reset, parameter RESET_VAL) SHALL be instantiated DEPTH times via generate.
REQ-032 pipe_regs SHALL contain only the ready chain, the occupancy counter logic and the stage instances.

Verification (WIDTH = 32, DEPTH = 3, RESET_VAL = 0)
REQ-033 reset = 0 with stages holding 0x3F -> out_data = 0, out_valid = 0, occupancy = 0 before the next clk edge.
REQ-034 Stream 0x21, 0x2AA, 0xF0 on consecutive cycles, out_ready = 1 -> out_data 0x21, 0x2AA, 0xF0 on cycles 3, 4, 5.
REQ-035 Fill with 0x11, 0x22, 0x33, out_ready = 0 -> occupancy = 3, in_ready = 0, out_data holds 0x11 for 4 cycles; raise out_ready -> 0x11, 0x22, 0x33 emitted in order.
REQ-036 Beats 0x1 and 0x3 with an idle cycle between them, out_ready = 0 -> bubble collapses, occupancy = 2, out_data = 0x1, no beat lost.
REQ-037 Flush with occupancy = 2 and in_valid = 1 (0x55) -> next cycle occupancy = 0, out_valid = 0, and 0x55 never appears on out_data.
REQ-038 Full pipeline, in_valid = out_ready = 1 for 10 cycles with values 1..10 -> one output per cycle, occupancy constant at 3, order preserved.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared constants and sizing helpers for the pipe_regs register slice.
package pipe_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 2;

  function automatic int occ_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/pipe_stage.sv
// One pipeline slot: valid flag plus payload register with load enable and sync clear.
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             gclk,
  input  logic             grst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             vin,
  input  logic [WIDTH-1:0] din,
  output logic             vout,
  output logic [WIDTH-1:0] dout
);

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      vout <= 1'b0;
      dout <= RESET_VAL;
    end else if (clr) begin
      vout <= 1'b0;
      dout <= RESET_VAL;
    end else if (en) begin
      vout <= vin;
      // a bubble moving in clears the flag but keeps the old payload
      if (vin) dout <= din;
    end
  end

endmodule

// File: rtl/pipe_regs.sv
// Bubble-collapsing valid/ready register pipeline of DEPTH stages with flush.
module pipe_regs
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter int               DEPTH     = DEF_DEPTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [occ_w(DEPTH)-1:0]    occupancy
);

  localparam int OW = occ_w(DEPTH);

  if (DEPTH < 1) begin : g_bad_depth
    $error("pipe_regs: DEPTH must be at least 1");
  end
  if (WIDTH < 1 || WIDTH > 1024) begin : g_bad_width
    $error("pipe_regs: WIDTH must be within 1..1024");
  end

  // index 0 is the upstream port; index i+1 is the output of stage i
  logic [DEPTH:0]            vld_pipe;
  logic [DEPTH:0][WIDTH-1:0] dat_pipe;
  logic [DEPTH:0]            rdy;

  assign vld_pipe[0] = in_valid;
  assign dat_pipe[0] = in_data;
  assign rdy[DEPTH]  = out_ready;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    assign rdy[i] = !vld_pipe[i+1] || rdy[i+1];

    pipe_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .gclk   (clk),
      .grst_n (reset),
      .en     (rdy[i]),
      .clr    (flush),
      .vin    (vld_pipe[i]),
      .din    (dat_pipe[i]),
      .vout   (vld_pipe[i+1]),
      .dout   (dat_pipe[i+1])
    );
  end

  assign in_ready  = rdy[0] && !flush;
  assign out_valid = vld_pipe[DEPTH] && !flush;
  assign out_data  = dat_pipe[DEPTH];

  always_comb begin
    occupancy = '0;
    for (int i = 1; i <= DEPTH; i++)
      occupancy = occupancy + OW'(vld_pipe[i]);
  end

endmodule

// File: tb/tb_pipe_regs.sv
// Directed bench for pipe_regs at WIDTH=32, DEPTH=3, RESET_VAL=0.
module tb_pipe_regs;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  occupancy;

  int total = 0;
  int bad   = 0;

  pipe_regs #(.WIDTH(32), .DEPTH(3), .RESET_VAL(32'h0)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
    end
  endtask

  // advance one edge, then settle away from it
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] v);
    in_valid = 1'b1;
    in_data  = v;
    cyc();
  endtask

  logic [31:0] vals [3];
  int          seen;

  initial begin
    reset     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    cyc();
    cyc();
    chk("rst_vld",   out_valid, 0);
    chk("rst_data",  out_data,  0);
    chk("rst_occ",   occupancy, 0);
    chk("rst_ready", in_ready,  1);
    reset = 1'b1;

    // streaming: first beat accepted on the first edge after release
    vals[0] = 32'h21; vals[1] = 32'h2AA; vals[2] = 32'hF0;
    out_ready = 1'b1;
    for (int n = 0; n < 6; n++) begin
      if (n < 3) begin in_valid = 1'b1; in_data = vals[n]; end
      else in_valid = 1'b0;
      cyc();
      if (n >= 2 && n <= 4) begin
        chk("strm_vld",  out_valid, 1);
        chk("strm_data", out_data,  vals[n-2]);
      end else begin
        chk("strm_idle", out_valid, 0);
      end
    end

    // async reset mid-cycle wipes a full pipe before any edge
    out_ready = 1'b0;
    push(32'h3F); push(32'h3F); push(32'h3F);
    in_valid = 1'b0;
    #1;
    chk("pre_arst_occ",  occupancy, 3);
    chk("pre_arst_data", out_data,  32'h3F);
    #1;
    reset = 1'b0;
    #1;
    chk("arst_data", out_data,  0);
    chk("arst_vld",  out_valid, 0);
    chk("arst_occ",  occupancy, 0);
    cyc();
    reset = 1'b1;

    // fill under backpressure, then drain in order
    push(32'h11); push(32'h22); push(32'h33);
    in_valid = 1'b1;
    in_data  = 32'h99;
    #1;
    chk("full_occ",   occupancy, 3);
    chk("full_ready", in_ready,  0);
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("stall_vld",  out_valid, 1);
      chk("stall_data", out_data,  32'h11);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("drain0", out_data, 32'h11);
    cyc();
    chk("drain1", out_data, 32'h22);
    cyc();
    chk("drain2", out_data, 32'h33);
    cyc();
    chk("drain_empty", out_valid, 0);
    chk("drain_occ",   occupancy, 0);

    // bubble between two beats collapses while the output stalls
    out_ready = 1'b0;
    push(32'h1);
    in_valid = 1'b0;
    cyc();
    push(32'h3);
    in_valid = 1'b0;
    cyc(); cyc(); cyc();
    chk("bub_occ",  occupancy, 2);
    chk("bub_data", out_data,  32'h1);
    chk("bub_vld",  out_valid, 1);
    out_ready = 1'b1;
    #1;
    chk("bub_out0", out_data, 32'h1);
    cyc();
    chk("bub_out1_vld", out_valid, 1);
    chk("bub_out1",     out_data,  32'h3);
    cyc();
    chk("bub_empty", occupancy, 0);

    // flush with two beats in flight and a new beat offered
    out_ready = 1'b0;
    push(32'hA1); push(32'hA2);
    in_valid = 1'b0;
    #1;
    chk("pre_flush_occ", occupancy, 2);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'h55;
    #1;
    chk("flush_ready", in_ready,  0);
    chk("flush_vld",   out_valid, 0);
    cyc();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("post_flush_occ",  occupancy, 0);
    chk("post_flush_vld",  out_valid, 0);
    chk("post_flush_data", out_data,  0);
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      cyc();
      if (out_valid) seen++;
    end
    chk("flush_no_leak", seen, 0);

    // full pipe: accept and emit each cycle, occupancy steady
    out_ready = 1'b0;
    push(32'd1); push(32'd2); push(32'd3);
    out_ready = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      in_valid = 1'b1;
      in_data  = 32'(k + 3);
      #1;
      chk("thru_ready", in_ready,  1);
      chk("thru_occ",   occupancy, 3);
      chk("thru_data",  out_data,  32'(k));
      cyc();
    end
    in_valid = 1'b0;
    #1;
    chk("thru_next", out_data, 32'd11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
